// File: rtl/alu_ctrl_muldiv_if.sv
// Bundle between the datapath and alu_ctrl_muldiv: instruction decode
// fields and operands in, ALU op / HI-LO readback / stall out.
interface alu_ctrl_muldiv_if #(
    parameter int WIDTH = 32
);
    logic [2:0]       AluCtrl;
    logic [5:0]       funct;
    logic             instr_vld;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [3:0]       AluOp;
    logic             hilo_sel;
    logic [WIDTH-1:0] hilo_data;
    logic             stall;
    logic             md_busy;

    modport master (
        output AluCtrl, funct, instr_vld, src_a, src_b,
        input  AluOp, hilo_sel, hilo_data, stall, md_busy
    );

    modport slave (
        input  AluCtrl, funct, instr_vld, src_a, src_b,
        output AluOp, hilo_sel, hilo_data, stall, md_busy
    );
endinterface

// File: rtl/alu_ctrl_muldiv.sv
// ALU control decode plus an iterative HI/LO multiply/divide engine.
// Shift-add multiply and restoring divide both operate on magnitudes in a
// shared {acc_hi, acc_lo} register pair; signs are applied in FIX.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | engine free; accepts mult/div start, mthi/mtlo, mfhi/mflo
//  MUL   | shift-add iteration, counter WIDTH-1 down to 0
//  DIV   | restoring-divide iteration, counter WIDTH-1 down to 0
//  FIX   | sign correction and HI/LO write, then back to IDLE
module alu_ctrl_muldiv #(
    parameter int WIDTH  = 32,
    parameter bit DIV_EN = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    alu_ctrl_muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2a;
    localparam logic [5:0] F_SLTU  = 6'h2b;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] acc_hi_q, acc_lo_q;
    logic [WIDTH-1:0] op_a_q, op_b_q;
    logic             is_div_q, neg_q_q, neg_r_q;

    logic [3:0]       alu_op;
    logic             is_r;
    logic             f_mult, f_multu, f_div, f_divu;
    logic             f_mfhi, f_mthi, f_mflo, f_mtlo;
    logic             is_hilo, md_busy, accept;
    logic             start_mul, start_div;

    // AluOp decode; unknown classes and functs fall back to add
    always_comb begin
        alu_op = 4'b0010;
        case (bus.AluCtrl)
            3'd0: alu_op = 4'b0000;
            3'd1: alu_op = 4'b0001;
            3'd2: alu_op = 4'b0010;
            3'd3: alu_op = 4'b0111;
            3'd4: alu_op = 4'b0011;
            3'd5: alu_op = 4'b0100;
            3'd6: alu_op = 4'b0101;
            default: begin
                case (bus.funct)
                    F_ADD:   alu_op = 4'b0010;
                    F_SUB:   alu_op = 4'b0110;
                    F_AND:   alu_op = 4'b0000;
                    F_OR:    alu_op = 4'b0001;
                    F_NOR:   alu_op = 4'b1100;
                    F_SLL:   alu_op = 4'b1001;
                    F_SRL:   alu_op = 4'b1010;
                    F_SRA:   alu_op = 4'b1011;
                    F_SLT:   alu_op = 4'b0111;
                    F_SLTU:  alu_op = 4'b0011;
                    default: alu_op = 4'b0010;
                endcase
            end
        endcase
    end

    assign is_r    = (bus.AluCtrl == 3'd7);
    assign f_mult  = is_r && (bus.funct == F_MULT);
    assign f_multu = is_r && (bus.funct == F_MULTU);
    // With the divider compiled out, div/divu are plain no-ops: no stall, no start
    assign f_div   = DIV_EN && is_r && (bus.funct == F_DIV);
    assign f_divu  = DIV_EN && is_r && (bus.funct == F_DIVU);
    assign f_mfhi  = is_r && (bus.funct == F_MFHI);
    assign f_mthi  = is_r && (bus.funct == F_MTHI);
    assign f_mflo  = is_r && (bus.funct == F_MFLO);
    assign f_mtlo  = is_r && (bus.funct == F_MTLO);
    assign is_hilo = f_mult | f_multu | f_div | f_divu | f_mfhi | f_mthi | f_mflo | f_mtlo;

    assign md_busy   = (state_q != S_IDLE);
    // Any HI/LO op that is valid and not stalled can only happen in IDLE
    assign accept    = bus.instr_vld & is_hilo & ~md_busy;
    assign start_mul = accept & (f_mult | f_multu);
    assign start_div = accept & (f_div | f_divu);

    assign bus.AluOp     = alu_op;
    assign bus.md_busy   = md_busy;
    assign bus.stall     = bus.instr_vld & md_busy & is_hilo;
    assign bus.hilo_sel  = accept & (f_mfhi | f_mflo);
    assign bus.hilo_data = (accept & f_mfhi) ? hi_q :
                           (accept & f_mflo) ? lo_q : '0;

    logic             op_signed, sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    // Operand magnitudes at start, one iteration step of each engine, and the FIX result
    always_comb begin
        op_signed = f_mult | f_div;
        sa        = op_signed & bus.src_a[WIDTH-1];
        sb        = op_signed & bus.src_b[WIDTH-1];
        mag_a     = sa ? -bus.src_a : bus.src_a;
        mag_b     = sb ? -bus.src_b : bus.src_b;

        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, op_a_q} : '0);

        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, op_b_q};

        prod_s    = neg_q_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
        fix_hi    = prod_s[2*WIDTH-1:WIDTH];
        fix_lo    = prod_s[WIDTH-1:0];
        if (is_div_q) begin
            if (op_b_q == '0) begin
                // Divide by zero: quotient saturates, remainder is the raw dividend
                fix_lo = '1;
                fix_hi = neg_r_q ? -op_a_q : op_a_q;
            end else begin
                fix_lo = neg_q_q ? -acc_lo_q : acc_lo_q;
                fix_hi = neg_r_q ? -acc_hi_q : acc_hi_q;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_mul)      state_d = S_MUL;
                else if (start_div) state_d = S_DIV;
            end
            S_MUL:   if (cnt_q == '0) state_d = S_FIX;
            S_DIV:   if (cnt_q == '0) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Engine datapath: operand latch, iteration, HI/LO writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_mul | start_div) begin
                        cnt_q    <= CW'(WIDTH - 1);
                        op_a_q   <= mag_a;
                        op_b_q   <= mag_b;
                        acc_hi_q <= '0;
                        acc_lo_q <= start_div ? mag_a : mag_b;
                        is_div_q <= start_div;
                        neg_q_q  <= sa ^ sb;
                        neg_r_q  <= sa;
                    end
                    if (accept & f_mthi) hi_q <= bus.src_a;
                    if (accept & f_mtlo) lo_q <= bus.src_a;
                end
                S_MUL: begin
                    {acc_hi_q, acc_lo_q} <= {mul_sum, acc_lo_q[WIDTH-1:1]};
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                S_DIV: begin
                    acc_hi_q <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                    acc_lo_q <= {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                S_FIX: begin
                    hi_q <= fix_hi;
                    lo_q <= fix_lo;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
module tb_alu_ctrl_muldiv;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_ctrl_muldiv_if #(.WIDTH(32)) b32 ();
    alu_ctrl_muldiv_if #(.WIDTH(8))  b8 ();

    alu_ctrl_muldiv #(.WIDTH(32), .DIV_EN(1'b1)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    alu_ctrl_muldiv #(.WIDTH(8),  .DIV_EN(1'b1)) dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    sb_t q32[$];
    sb_t q8[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon32
        sb_t e;
        if (rst_n && b32.hilo_sel === 1'b1) begin
            if (q32.size() == 0) begin
                checks++; failures++;
                $display("FAIL rd32_unexpected: got %h expected no read", b32.hilo_data);
            end else begin
                e = q32.pop_front();
                check(e.name, b32.hilo_data, e.exp);
            end
        end
    end

    always @(negedge clk) begin : mon8
        sb_t e;
        if (rst_n && b8.hilo_sel === 1'b1) begin
            if (q8.size() == 0) begin
                checks++; failures++;
                $display("FAIL rd8_unexpected: got %h expected no read", b8.hilo_data);
            end else begin
                e = q8.pop_front();
                check(e.name, {24'b0, b8.hilo_data}, e.exp);
            end
        end
    end

    task automatic drive(input int w, input logic [2:0] ctrl, input logic [5:0] f, input logic vld,
                         input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        if (w == 8) begin
            b8.AluCtrl = ctrl; b8.funct = f; b8.instr_vld = vld;
            b8.src_a = a[7:0]; b8.src_b = b[7:0];
        end else begin
            b32.AluCtrl = ctrl; b32.funct = f; b32.instr_vld = vld;
            b32.src_a = a; b32.src_b = b;
        end
    endtask

    task automatic op(input int w, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        drive(w, 3'd7, f, 1'b1, a, b);
    endtask

    task automatic idle(input int w);
        drive(w, 3'd0, 6'h00, 1'b0, 32'h0, 32'h0);
    endtask

    // Issue mfhi/mflo, queue the expected readback, and count stalled cycles
    task automatic rd(input int w, input logic [5:0] f, input string name,
                      input logic [31:0] exp, input int exp_stall);
        sb_t e;
        int  n;
        logic st;
        logic released;
        e.name = name;
        e.exp  = exp;
        drive(w, 3'd7, f, 1'b1, 32'h0, 32'h0);
        if (w == 8) q8.push_back(e);
        else        q32.push_back(e);
        n = 0;
        released = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            st = (w == 8) ? b8.stall : b32.stall;
            if (st !== 1'b1) begin
                released = 1'b1;
                break;
            end
            n++;
        end
        if (!released) begin
            checks++; failures++;
            $display("FAIL %s_timeout: got stall still high expected release", name);
        end else begin
            check({name, "_stall"}, 32'(n), 32'(exp_stall));
        end
    endtask

    task automatic dec(input string name, input logic [2:0] ctrl, input logic [5:0] f, input logic [3:0] exp);
        drive(32, ctrl, f, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check(name, {28'b0, b32.AluOp}, {28'b0, exp});
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        b32.AluCtrl = '0; b32.funct = '0; b32.instr_vld = 1'b0; b32.src_a = '0; b32.src_b = '0;
        b8.AluCtrl  = '0; b8.funct  = '0; b8.instr_vld  = 1'b0; b8.src_a  = '0; b8.src_b  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy",  {31'b0, b32.md_busy},  32'h0);
        check("rst_stall", {31'b0, b32.stall},    32'h0);
        check("rst_sel",   {31'b0, b32.hilo_sel}, 32'h0);
        check("rst_data",  b32.hilo_data,         32'h0);

        // Decode sweep
        dec("dec_c0", 3'd0, 6'h00, 4'b0000);
        dec("dec_c1", 3'd1, 6'h00, 4'b0001);
        dec("dec_c2", 3'd2, 6'h00, 4'b0010);
        dec("dec_c3", 3'd3, 6'h00, 4'b0111);
        dec("dec_c4", 3'd4, 6'h00, 4'b0011);
        dec("dec_c5", 3'd5, 6'h00, 4'b0100);
        dec("dec_c6", 3'd6, 6'h00, 4'b0101);
        dec("dec_add",  3'd7, 6'h20, 4'b0010);
        dec("dec_sub",  3'd7, 6'h22, 4'b0110);
        dec("dec_and",  3'd7, 6'h24, 4'b0000);
        dec("dec_or",   3'd7, 6'h25, 4'b0001);
        dec("dec_nor",  3'd7, 6'h27, 4'b1100);
        dec("dec_sll",  3'd7, 6'h00, 4'b1001);
        dec("dec_srl",  3'd7, 6'h02, 4'b1010);
        dec("dec_sra",  3'd7, 6'h03, 4'b1011);
        dec("dec_slt",  3'd7, 6'h2a, 4'b0111);
        dec("dec_sltu", 3'd7, 6'h2b, 4'b0011);
        dec("dec_3f",   3'd7, 6'h3f, 4'b0010);
        dec("dec_mult", 3'd7, 6'h18, 4'b0010);
        dec("dec_mfhi", 3'd7, 6'h10, 4'b0010);

        // HI/LO zero after reset
        rd(32, 6'h10, "rst_hi", 32'h0, 0);
        rd(32, 6'h12, "rst_lo", 32'h0, 0);

        // mult / multu, read issued the cycle after start
        op(32, 6'h18, 32'hFFFF_FFFD, 32'h7);
        rd(32, 6'h10, "mult_hi", 32'hFFFF_FFFF, 33);
        rd(32, 6'h12, "mult_lo", 32'hFFFF_FFEB, 0);
        op(32, 6'h19, 32'hFFFF_FFFD, 32'h7);
        rd(32, 6'h12, "multu_lo", 32'hFFFF_FFEB, 33);
        rd(32, 6'h10, "multu_hi", 32'h0000_0006, 0);

        // div / divu including divide-by-zero and signed overflow
        op(32, 6'h1a, 32'hFFFF_FFF9, 32'h2);
        rd(32, 6'h12, "div_lo", 32'hFFFF_FFFD, 33);
        rd(32, 6'h10, "div_hi", 32'hFFFF_FFFF, 0);
        op(32, 6'h1b, 32'h7, 32'h0);
        rd(32, 6'h12, "divu0_lo", 32'hFFFF_FFFF, 33);
        rd(32, 6'h10, "divu0_hi", 32'h0000_0007, 0);
        op(32, 6'h1a, 32'h8000_0000, 32'hFFFF_FFFF);
        rd(32, 6'h12, "divovf_lo", 32'h8000_0000, 33);
        rd(32, 6'h10, "divovf_hi", 32'h0, 0);

        // mthi/mtlo, then an invalid mult must not disturb HI/LO
        op(32, 6'h11, 32'h1234, 32'h0);
        op(32, 6'h13, 32'h5678, 32'h0);
        drive(32, 3'd7, 6'h18, 1'b0, 32'h3, 32'h3);
        @(negedge clk);
        check("nvld_stall", {31'b0, b32.stall}, 32'h0);
        @(negedge clk);
        check("nvld_busy", {31'b0, b32.md_busy}, 32'h0);
        rd(32, 6'h10, "mthi_hi", 32'h1234, 0);
        rd(32, 6'h12, "mtlo_lo", 32'h5678, 0);

        // Reset in the middle of a divide
        op(32, 6'h1a, 32'd100, 32'd7);
        idle(32);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'b0, b32.md_busy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(32, 6'h10, "midrst_hi", 32'h0, 0);
        rd(32, 6'h12, "midrst_lo", 32'h0, 0);
        op(32, 6'h18, 32'd5, 32'd6);
        rd(32, 6'h12, "postrst_lo", 32'd30, 33);
        rd(32, 6'h10, "postrst_hi", 32'h0, 0);
        idle(32);

        // WIDTH=8 instance
        op(8, 6'h18, 32'hFD, 32'h07);
        rd(8, 6'h10, "w8_mult_hi", 32'hFF, 9);
        rd(8, 6'h12, "w8_mult_lo", 32'hEB, 0);
        op(8, 6'h19, 32'hFD, 32'h07);
        rd(8, 6'h10, "w8_multu_hi", 32'h06, 9);
        rd(8, 6'h12, "w8_multu_lo", 32'hEB, 0);
        op(8, 6'h1a, 32'hF9, 32'h02);
        rd(8, 6'h12, "w8_div_lo", 32'hFD, 9);
        rd(8, 6'h10, "w8_div_hi", 32'hFF, 0);
        op(8, 6'h1b, 32'h07, 32'h00);
        rd(8, 6'h12, "w8_divu0_lo", 32'hFF, 9);
        rd(8, 6'h10, "w8_divu0_hi", 32'h07, 0);
        op(8, 6'h1a, 32'h80, 32'hFF);
        rd(8, 6'h12, "w8_divovf_lo", 32'h80, 9);
        rd(8, 6'h10, "w8_divovf_hi", 32'h00, 0);
        idle(8);

        repeat (3) @(posedge clk);
        check("sb32_drained", 32'(q32.size()), 32'h0);
        check("sb8_drained",  32'(q8.size()),  32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
